mem_access_unit: RTL and testbench

Load/store sequencer between the core's execute stage and the single-port data memory. Accepts one memory request at a time over a valid/ready handshake and drives the memory's write enable, address and write-data inputs. Captures the memory's asynchronous read data and returns a response over a second valid/ready handshake. Optionally performs an atomic read-modify-write add.

---
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response handshakes and data-memory port of mem_access_unit.
// The unit connects through the slave modport; core and memory use the master side.
interface mem_access_unit_if #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 5
);
   logic                 REQ_VALID;
   logic                 REQ_READY;
   logic [1:0]           REQ_OP;
   logic [ADDR_SIZE-1:0] REQ_ADDR;
   logic [DATA_SIZE-1:0] REQ_DATA;
   logic                 RSP_VALID;
   logic                 RSP_READY;
   logic [DATA_SIZE-1:0] RSP_DATA;
   logic                 RSP_CARRY;
   logic                 RSP_ERR;
   logic                 MEM_W;
   logic [ADDR_SIZE-1:0] MEM_ADDR;
   logic [DATA_SIZE-1:0] MEM_WR;
   logic [DATA_SIZE-1:0] MEM_RD;

   modport slave (
      input  REQ_VALID, REQ_OP, REQ_ADDR, REQ_DATA, RSP_READY, MEM_RD,
      output REQ_READY, RSP_VALID, RSP_DATA, RSP_CARRY, RSP_ERR, MEM_W, MEM_ADDR, MEM_WR
   );

   modport master (
      output REQ_VALID, REQ_OP, REQ_ADDR, REQ_DATA, RSP_READY, MEM_RD,
      input  REQ_READY, RSP_VALID, RSP_DATA, RSP_CARRY, RSP_ERR, MEM_W, MEM_ADDR, MEM_WR
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and a single-port data memory.
// Define MEM_ACCESS_RMW_EN to enable the atomic read-modify-write ADD (op 10).
module mem_access_unit #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 5
) (
   input  logic             clk,
   input  logic             rstn,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_ADD   = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

`ifdef MEM_ACCESS_RMW_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_MODIFY = 2'd2, S_RESP = 2'd3} state_e;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd3} state_e;
`endif

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_SIZE-1:0] mem_wr_q, mem_wr_d;
   logic                 mem_w_q, mem_w_d;
   logic [DATA_SIZE-1:0] rsp_data_q, rsp_data_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 req_legal;
`ifdef MEM_ACCESS_RMW_EN
   logic                 rsp_carry_q, rsp_carry_d;
   logic [DATA_SIZE:0]   sum;
`endif

   // NOTE: every signal gets a default before the case so no branch can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      mem_addr_d = mem_addr_q;
      mem_wr_d   = mem_wr_q;
      mem_w_d    = 1'b0;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
`ifdef MEM_ACCESS_RMW_EN
      rsp_carry_d = rsp_carry_q;
      sum         = {1'b0, bus.MEM_RD} + {1'b0, mem_wr_q};
      req_legal   = (bus.REQ_OP != OP_RSVD);
`else
      req_legal   = (bus.REQ_OP == OP_LOAD) || (bus.REQ_OP == OP_STORE);
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.REQ_VALID) begin
               // The write-data register doubles as the latched store data / addend.
               op_d       = op_e'(bus.REQ_OP);
               mem_addr_d = bus.REQ_ADDR;
               mem_wr_d   = bus.REQ_DATA;
               rsp_data_d = '0;
`ifdef MEM_ACCESS_RMW_EN
               rsp_carry_d = 1'b0;
`endif
               if (req_legal) begin
                  state_d   = S_ACCESS;
                  rsp_err_d = 1'b0;
                  mem_w_d   = (bus.REQ_OP == OP_STORE);
               end else begin
                  state_d   = S_RESP;
                  rsp_err_d = 1'b1;
               end
            end
         end

         S_ACCESS: begin
            state_d = S_RESP;
            case (op_q)
               OP_STORE: rsp_data_d = mem_wr_q;
`ifdef MEM_ACCESS_RMW_EN
               OP_ADD: begin
                  // Old value becomes the response; the sum is written during MODIFY.
                  rsp_data_d  = bus.MEM_RD;
                  rsp_carry_d = sum[DATA_SIZE];
                  mem_wr_d    = sum[DATA_SIZE-1:0];
                  mem_w_d     = 1'b1;
                  state_d     = S_MODIFY;
               end
`endif
               default:  rsp_data_d = bus.MEM_RD;
            endcase
         end

`ifdef MEM_ACCESS_RMW_EN
         S_MODIFY: state_d = S_RESP;
`endif

         S_RESP: begin
            if (bus.RSP_READY) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LOAD;
         mem_addr_q  <= '0;
         mem_wr_q    <= '0;
         mem_w_q     <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
`ifdef MEM_ACCESS_RMW_EN
         rsp_carry_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         mem_addr_q  <= mem_addr_d;
         mem_wr_q    <= mem_wr_d;
         mem_w_q     <= mem_w_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
`ifdef MEM_ACCESS_RMW_EN
         rsp_carry_q <= rsp_carry_d;
`endif
      end
   end

   assign bus.REQ_READY = (state_q == S_IDLE);
   assign bus.RSP_VALID = (state_q == S_RESP);
   assign bus.RSP_DATA  = rsp_data_q;
   assign bus.RSP_ERR   = rsp_err_q;
   assign bus.MEM_W     = mem_w_q;
   assign bus.MEM_ADDR  = mem_addr_q;
   assign bus.MEM_WR    = mem_wr_q;
`ifdef MEM_ACCESS_RMW_EN
   assign bus.RSP_CARRY = rsp_carry_q;
`else
   assign bus.RSP_CARRY = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// reset/hold sequences and randomized transactions against a reference model.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_RMW_EN
   localparam bit RMW = 1'b1;
`else
   localparam bit RMW = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       carry;
      logic       err;
      int         lat;
      int         writes;
      logic [4:0] waddr;
      logic [7:0] wdata;
   } rsp_t;

   typedef struct {
      logic [1:0] op;
      logic [4:0] addr;
      logic [7:0] data;
      int         hold;
      rsp_t       exp;
   } vec_t;

   logic clk;
   logic rstn;
   int   n_vec;
   int   n_miss;
   int   wr_count;
   logic [4:0] last_waddr;
   logic [7:0] last_wdata;
   logic [7:0] mem [32];
   logic [7:0] ref_mem [32];

   mem_access_unit_if #(.DATA_SIZE(8), .ADDR_SIZE(5)) bus ();

   mem_access_unit #(.DATA_SIZE(8), .ADDR_SIZE(5)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: asynchronous read, synchronous write, reset contents mem[i] = i.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
      end else if (bus.MEM_W) begin
         mem[bus.MEM_ADDR] <= bus.MEM_WR;
      end
   end
   assign bus.MEM_RD = mem[bus.MEM_ADDR];

   always @(negedge clk) begin
      if (bus.MEM_W === 1'b1) begin
         wr_count++;
         last_waddr = bus.MEM_ADDR;
         last_wdata = bus.MEM_WR;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic rsp_t mk(input logic [7:0] d, input logic c, input logic e,
                               input int lat, input int w, input logic [4:0] wa, input logic [7:0] wd);
      rsp_t r;
      r.data = d; r.carry = c; r.err = e; r.lat = lat; r.writes = w; r.waddr = wa; r.wdata = wd;
      return r;
   endfunction

   // Reference model: whole-transaction behaviour over an abstract memory array.
   function automatic rsp_t model(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d);
      rsp_t r;
      int   s;
      r = mk(8'h00, 1'b0, 1'b1, 1, 0, a, 8'h00);
      if (op == 2'b00) begin
         r = mk(ref_mem[a], 1'b0, 1'b0, 2, 0, a, 8'h00);
      end else if (op == 2'b01) begin
         r = mk(d, 1'b0, 1'b0, 2, 1, a, d);
         ref_mem[a] = d;
      end else if (op == 2'b10 && RMW) begin
         s = int'(ref_mem[a]) + int'(d);
         r = mk(ref_mem[a], s > 255, 1'b0, 3, 1, a, 8'(s % 256));
         ref_mem[a] = 8'(s % 256);
      end
      return r;
   endfunction

   task automatic ref_reset();
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      ref_reset();
   endtask

   task automatic transact(input string tag, input logic [1:0] op, input logic [4:0] addr,
                           input logic [7:0] data, input int hold, input rsp_t exp);
      int n;
      int lat;
      int w0;
      n = 0;
      while (!bus.REQ_READY && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " req_ready"}, 32'(bus.REQ_READY), 32'd1);
      w0 = wr_count;
      bus.REQ_VALID = 1'b1;
      bus.REQ_OP    = op;
      bus.REQ_ADDR  = addr;
      bus.REQ_DATA  = data;
      @(negedge clk);
      bus.REQ_VALID = 1'b0;
      lat = 1;
      while (!bus.RSP_VALID && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp.lat));
      check({tag, " rsp_data"}, 32'(bus.RSP_DATA), 32'(exp.data));
      check({tag, " rsp_carry"}, 32'(bus.RSP_CARRY), 32'(exp.carry));
      check({tag, " rsp_err"}, 32'(bus.RSP_ERR), 32'(exp.err));
      for (int i = 0; i < hold; i++) begin
         bus.REQ_VALID = 1'b1;
         bus.REQ_OP    = 2'b01;
         bus.REQ_ADDR  = 5'h1e;
         bus.REQ_DATA  = 8'h33;
         @(negedge clk);
         check({tag, " hold rsp_valid"}, 32'(bus.RSP_VALID), 32'd1);
         check({tag, " hold rsp_data"}, 32'(bus.RSP_DATA), 32'(exp.data));
         check({tag, " hold req_ready"}, 32'(bus.REQ_READY), 32'd0);
      end
      bus.REQ_VALID = 1'b0;
      bus.RSP_READY = 1'b1;
      @(negedge clk);
      bus.RSP_READY = 1'b0;
      check({tag, " ready after consume"}, 32'(bus.REQ_READY), 32'd1);
      check({tag, " valid after consume"}, 32'(bus.RSP_VALID), 32'd0);
      check({tag, " write pulses"}, 32'(wr_count - w0), 32'(exp.writes));
      if (exp.writes > 0) begin
         check({tag, " write addr"}, 32'(last_waddr), 32'(exp.waddr));
         check({tag, " write data"}, 32'(last_wdata), 32'(exp.wdata));
      end
      if (!exp.err) check({tag, " idle mem_addr"}, 32'(bus.MEM_ADDR), 32'(addr));
   endtask

   vec_t vecs [12];
   rsp_t exp_r;
   logic [1:0] r_op;
   logic [4:0] r_addr;
   logic [7:0] r_data;

   initial begin
      n_vec = 0;
      n_miss = 0;
      wr_count = 0;
      last_waddr = '0;
      last_wdata = '0;
      rstn = 1'b1;
      bus.REQ_VALID = 1'b0;
      bus.REQ_OP    = 2'b00;
      bus.REQ_ADDR  = '0;
      bus.REQ_DATA  = '0;
      bus.RSP_READY = 1'b0;
      #2;
      do_reset();

      check("reset req_ready", 32'(bus.REQ_READY), 32'd1);
      check("reset rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      check("reset rsp_data", 32'(bus.RSP_DATA), 32'd0);
      check("reset rsp_carry", 32'(bus.RSP_CARRY), 32'd0);
      check("reset rsp_err", 32'(bus.RSP_ERR), 32'd0);
      check("reset mem_w", 32'(bus.MEM_W), 32'd0);
      check("reset mem_addr", 32'(bus.MEM_ADDR), 32'd0);
      check("reset mem_wr", 32'(bus.MEM_WR), 32'd0);

      // Directed table, starting from the memory reset pattern mem[i] = i.
      vecs[0]  = '{2'b00, 5'd5,  8'h00, 10, mk(8'h05, 0, 0, 2, 0, 5'd5, 8'h00)};
      vecs[1]  = '{2'b01, 5'd3,  8'hA5, 0,  mk(8'hA5, 0, 0, 2, 1, 5'd3, 8'hA5)};
      vecs[2]  = '{2'b00, 5'd3,  8'h00, 0,  mk(8'hA5, 0, 0, 2, 0, 5'd3, 8'h00)};
      vecs[3]  = '{2'b10, 5'd31, 8'hF0, 0,  RMW ? mk(8'h1F, 1, 0, 3, 1, 5'd31, 8'h0F)
                                                : mk(8'h00, 0, 1, 1, 0, 5'd31, 8'h00)};
      vecs[4]  = '{2'b00, 5'd31, 8'h00, 0,  mk(RMW ? 8'h0F : 8'h1F, 0, 0, 2, 0, 5'd31, 8'h00)};
      vecs[5]  = '{2'b11, 5'd7,  8'h5A, 0,  mk(8'h00, 0, 1, 1, 0, 5'd7, 8'h00)};
      vecs[6]  = '{2'b00, 5'd7,  8'h00, 0,  mk(8'h07, 0, 0, 2, 0, 5'd7, 8'h00)};
      vecs[7]  = '{2'b10, 5'd4,  8'h01, 0,  RMW ? mk(8'h04, 0, 0, 3, 1, 5'd4, 8'h05)
                                                : mk(8'h00, 0, 1, 1, 0, 5'd4, 8'h00)};
      vecs[8]  = '{2'b00, 5'd4,  8'h00, 0,  mk(RMW ? 8'h05 : 8'h04, 0, 0, 2, 0, 5'd4, 8'h00)};
      vecs[9]  = '{2'b01, 5'd0,  8'hFF, 0,  mk(8'hFF, 0, 0, 2, 1, 5'd0, 8'hFF)};
      vecs[10] = '{2'b10, 5'd0,  8'h01, 0,  RMW ? mk(8'hFF, 1, 0, 3, 1, 5'd0, 8'h00)
                                                : mk(8'h00, 0, 1, 1, 0, 5'd0, 8'h00)};
      vecs[11] = '{2'b00, 5'd0,  8'h00, 0,  mk(RMW ? 8'h00 : 8'hFF, 0, 0, 2, 0, 5'd0, 8'h00)};

      for (int i = 0; i < 12; i++) begin
         transact($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].hold, vecs[i].exp);
      end

      // Reset while the write of an ADD (or a STORE without RMW) is on the memory port.
      do_reset();
      bus.REQ_VALID = 1'b1;
      bus.REQ_OP    = RMW ? 2'b10 : 2'b01;
      bus.REQ_ADDR  = 5'd2;
      bus.REQ_DATA  = 8'h10;
      @(negedge clk);
      bus.REQ_VALID = 1'b0;
      if (RMW) @(negedge clk);
      check("mid-op mem_w before reset", 32'(bus.MEM_W), 32'd1);
      #1 rstn = 1'b0;
      #1;
      check("mid-op mem_w in reset", 32'(bus.MEM_W), 32'd0);
      check("mid-op rsp_valid in reset", 32'(bus.RSP_VALID), 32'd0);
      check("mid-op req_ready in reset", 32'(bus.REQ_READY), 32'd1);
      @(negedge clk);
      rstn = 1'b1;
      ref_reset();
      transact("mid-op reload", 2'b00, 5'd2, 8'h00, 0, model(2'b00, 5'd2, 8'h00));

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         r_op   = 2'($urandom_range(0, 3));
         r_addr = 5'($urandom_range(0, 31));
         r_data = 8'($urandom);
         exp_r  = model(r_op, r_addr, r_data);
         transact($sformatf("rnd%0d", i), r_op, r_addr, r_data, int'($urandom_range(0, 2)), exp_r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
